// File: rtl/psum_acc_requant_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_acc_requant_pkg
//  Description : Shared widths, FSM state encoding and accumulator width check
//                for the partial-sum accumulate / requantise block.
//  Revision    : 1.0  initial release
// ============================================================================
package psum_acc_requant_pkg;

    localparam int NF     = 40;
    localparam int PSUM_W = 22;
    localparam int BIAS_W = 16;
    localparam int NGRP_W = 8;
    localparam int ACC_W  = 32;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        QUANT = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // The accumulator must hold bias plus up to 2^NGRP_W partial sums without wrapping.
    function automatic logic acc_w_ok(input int acc_w, input int psum_w, input int ngrp_w);
        return (acc_w >= psum_w + ngrp_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/psum_acc_requant_requant_lane.sv
`default_nettype none
// ============================================================================
//  Module      : requant_lane
//  Description : Combinational round-half-up arithmetic right shift, optional
//                ReLU and int8 saturation for one accumulator lane.
//  Revision    : 1.0  initial release
// ============================================================================
module requant_lane
    import psum_acc_requant_pkg::*;
(
    input  logic signed [ACC_W-1:0] i_acc,
    input  logic        [4:0]       i_shift,
    input  logic                    i_relu,
    output logic signed [7:0]       o_q
);

    // One guard bit so adding the rounding constant can never overflow.
    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_inc;
    logic signed [ACC_W:0] w_sum;
    logic signed [ACC_W:0] w_r;

    always_comb begin
        w_ext = {i_acc[ACC_W-1], i_acc};
        w_inc = '0;
        w_sum = w_ext;
        w_r   = w_ext;
        if (i_shift != 5'd0) begin
            w_inc = {{ACC_W{1'b0}}, 1'b1} << (i_shift - 5'd1);
            w_sum = w_ext + w_inc;
            w_r   = w_sum >>> i_shift;
        end
        if (i_relu && w_r[ACC_W]) begin
            w_r = '0;
        end
        if (w_r > 127) begin
            o_q = 8'sd127;
        end else if (w_r < -128) begin
            o_q = -8'sd128;
        end else begin
            o_q = w_r[7:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/psum_acc_requant.sv
`default_nettype none
// ============================================================================
//  Module      : psum_acc_requant
//  Description : Accumulates per-filter partial sums over channel groups, adds
//                bias, requantises to int8 and streams NF results per pixel.
//  Revision    : 1.0  initial release
// ============================================================================
module psum_acc_requant
    import psum_acc_requant_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NGRP_W-1:0]        cfg_ngrp,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic [NF*BIAS_W-1:0]     bias_i,
    input  logic [NF*PSUM_W-1:0]     psum_i,
    input  logic                     psum_vld_i,
    output logic                     psum_rdy_o,
    output logic [7:0]               out_data_o,
    output logic [5:0]               out_idx_o,
    output logic                     out_vld_o,
    input  logic                     out_rdy_i,
    output logic                     err_o
);

    localparam logic [NGRP_W-1:0] c_ngrp_one = {{(NGRP_W-1){1'b0}}, 1'b1};
    localparam logic [5:0]        c_last_idx = 6'(NF - 1);

    generate
        if (!acc_w_ok(ACC_W, PSUM_W, NGRP_W)) begin : g_acc_w_bad
            $error("psum_acc_requant: ACC_W too narrow for PSUM_W and NGRP_W");
        end
    endgenerate

    state_e                   r_state;
    logic [NGRP_W-1:0]        r_grp_cnt;
    logic [NGRP_W-1:0]        r_ngrp;
    logic [4:0]               r_shift;
    logic                     r_relu;
    logic signed [ACC_W-1:0]  r_acc [NF];
    logic [7:0]               r_q   [NF];

    logic signed [ACC_W-1:0]  w_bias_ext [NF];
    logic signed [ACC_W-1:0]  w_psum_ext [NF];
    logic signed [7:0]        w_q        [NF];
    logic [NGRP_W-1:0]        w_cfg_ngrp;
    logic                     w_last_grp;
    logic [5:0]               w_idx_nxt;

    generate
        for (genvar f = 0; f < NF; f++) begin : g_lane
            assign w_bias_ext[f] = {{(ACC_W-BIAS_W){bias_i[f*BIAS_W+BIAS_W-1]}},
                                    bias_i[f*BIAS_W +: BIAS_W]};
            assign w_psum_ext[f] = {{(ACC_W-PSUM_W){psum_i[f*PSUM_W+PSUM_W-1]}},
                                    psum_i[f*PSUM_W +: PSUM_W]};

            requant_lane u_requant_lane (
                .i_acc   (r_acc[f]),
                .i_shift (r_shift),
                .i_relu  (r_relu),
                .o_q     (w_q[f])
            );
        end
    endgenerate

    // A zero group count behaves as a single group.
    assign w_cfg_ngrp = (cfg_ngrp == '0) ? c_ngrp_one : cfg_ngrp;
    // At group 0 the latched count is not yet valid, so judge from the live config.
    assign w_last_grp = (r_grp_cnt == '0) ? (w_cfg_ngrp == c_ngrp_one)
                                          : (r_grp_cnt == r_ngrp - c_ngrp_one);
    assign w_idx_nxt  = out_idx_o + 6'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ACCUM;
            r_grp_cnt  <= '0;
            r_ngrp     <= c_ngrp_one;
            r_shift    <= '0;
            r_relu     <= 1'b0;
            psum_rdy_o <= 1'b1;
            out_vld_o  <= 1'b0;
            out_idx_o  <= '0;
            out_data_o <= '0;
            err_o      <= 1'b0;
            for (int f = 0; f < NF; f++) begin
                r_acc[f] <= '0;
                r_q[f]   <= '0;
            end
        end else begin
            case (r_state)
                ACCUM: begin
                    if (psum_vld_i) begin
                        if (r_grp_cnt == '0) begin
                            r_ngrp  <= w_cfg_ngrp;
                            r_shift <= cfg_shift;
                            r_relu  <= cfg_relu;
                            for (int f = 0; f < NF; f++) begin
                                r_acc[f] <= w_bias_ext[f] + w_psum_ext[f];
                            end
                        end else begin
                            for (int f = 0; f < NF; f++) begin
                                r_acc[f] <= r_acc[f] + w_psum_ext[f];
                            end
                        end
                        if (w_last_grp) begin
                            r_grp_cnt  <= '0;
                            r_state    <= QUANT;
                            psum_rdy_o <= 1'b0;
                        end else begin
                            r_grp_cnt  <= r_grp_cnt + c_ngrp_one;
                        end
                    end
                end
                QUANT: begin
                    for (int f = 0; f < NF; f++) begin
                        r_q[f] <= w_q[f];
                    end
                    out_data_o <= w_q[0];
                    out_idx_o  <= '0;
                    out_vld_o  <= 1'b1;
                    r_state    <= DRAIN;
                end
                DRAIN: begin
                    if (out_vld_o && out_rdy_i) begin
                        if (out_idx_o == c_last_idx) begin
                            out_vld_o  <= 1'b0;
                            out_idx_o  <= '0;
                            psum_rdy_o <= 1'b1;
                            r_state    <= ACCUM;
                        end else begin
                            out_idx_o  <= w_idx_nxt;
                            out_data_o <= r_q[w_idx_nxt];
                        end
                    end
                end
                default: begin
                    r_state    <= ACCUM;
                    r_grp_cnt  <= '0;
                    psum_rdy_o <= 1'b1;
                    out_vld_o  <= 1'b0;
                end
            endcase
            if (psum_vld_i && !psum_rdy_o) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_psum_acc_requant.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_acc_requant
//  Description : Directed self-checking bench for psum_acc_requant.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_psum_acc_requant;
    import psum_acc_requant_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NGRP_W-1:0]    cfg_ngrp;
    logic [4:0]           cfg_shift;
    logic                 cfg_relu;
    logic [NF*BIAS_W-1:0] bias_i;
    logic [NF*PSUM_W-1:0] psum_i;
    logic                 psum_vld_i;
    logic                 psum_rdy_o;
    logic [7:0]           out_data_o;
    logic [5:0]           out_idx_o;
    logic                 out_vld_o;
    logic                 out_rdy_i;
    logic                 err_o;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] got [64];

    psum_acc_requant dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_ngrp   (cfg_ngrp),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .bias_i     (bias_i),
        .psum_i     (psum_i),
        .psum_vld_i (psum_vld_i),
        .psum_rdy_o (psum_rdy_o),
        .out_data_o (out_data_o),
        .out_idx_o  (out_idx_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_psum(input int f, input int v);
        psum_i[f*PSUM_W +: PSUM_W] = PSUM_W'(v);
    endtask

    task automatic set_bias(input int f, input int v);
        bias_i[f*BIAS_W +: BIAS_W] = BIAS_W'(v);
    endtask

    task automatic pulse_vld();
        psum_vld_i = 1'b1;
        step();
        psum_vld_i = 1'b0;
    endtask

    // Collects beats into got[] by index with out_rdy_i held high.
    task automatic drain(input string tag);
        int n = 0;
        out_rdy_i = 1'b1;
        for (int c = 0; c < 200 && n < NF; c++) begin
            if (out_vld_o) begin
                got[out_idx_o] = out_data_o;
                n++;
            end
            step();
        end
        chk({tag, "_beats"}, n, NF);
        chk({tag, "_vld_low"}, out_vld_o, 1'b0);
        chk({tag, "_rdy_back"}, psum_rdy_o, 1'b1);
    endtask

    initial begin
        rst = 1'b1; cfg_ngrp = 8'd1; cfg_shift = 5'd0; cfg_relu = 1'b0;
        bias_i = '0; psum_i = '0; psum_vld_i = 1'b0; out_rdy_i = 1'b1;
        #1;
        step(); step(); step();
        chk("rst_psum_rdy", psum_rdy_o, 1'b1);
        chk("rst_out_vld",  out_vld_o,  1'b0);
        chk("rst_out_idx",  out_idx_o,  6'd0);
        chk("rst_out_data", out_data_o, 8'd0);
        chk("rst_err",      err_o,      1'b0);
        rst = 1'b0;
        step();

        // 1: single group, psum lane f = f, two-cycle latency, in-order drain
        for (int f = 0; f < NF; f++) set_psum(f, f);
        pulse_vld();
        chk("t1_vld_quant", out_vld_o, 1'b0);
        chk("t1_rdy_quant", psum_rdy_o, 1'b0);
        step();
        chk("t1_first_vld", out_vld_o, 1'b1);
        for (int k = 0; k < NF; k++) begin
            chk("t1_idx",  out_idx_o,  k);
            chk("t1_data", out_data_o, k);
            step();
        end
        chk("t1_vld_end", out_vld_o, 1'b0);
        chk("t1_rdy_end", psum_rdy_o, 1'b1);

        // 2: three groups with bias and shift 2; cfg changed mid-pixel must be ignored
        cfg_ngrp = 8'd3; cfg_shift = 5'd2; psum_i = '0; bias_i = '0;
        set_bias(0, 10); set_bias(1, -6);
        set_psum(0, 100);
        pulse_vld();
        chk("t2_rdy_g1", psum_rdy_o, 1'b1);
        cfg_shift = 5'd0; cfg_ngrp = 8'd1; cfg_relu = 1'b1;
        set_psum(0, 200);
        pulse_vld();
        chk("t2_rdy_g2", psum_rdy_o, 1'b1);
        set_psum(0, -50);
        pulse_vld();
        chk("t2_rdy_g3", psum_rdy_o, 1'b0);
        step();
        chk("t2_vld",  out_vld_o,  1'b1);
        chk("t2_idx0", out_idx_o,  6'd0);
        chk("t2_data0", out_data_o, 8'd65);
        drain("t2");
        chk("t2_lane1_round", got[1], 8'hFF);
        chk("t2_lane2_zero",  got[2], 8'd0);

        // 3: saturation both ways, then ReLU on the negative lane
        cfg_ngrp = 8'd2; cfg_shift = 5'd0; cfg_relu = 1'b0; bias_i = '0; psum_i = '0;
        set_psum(0, 2000000); set_psum(1, -2000000); set_psum(2, -3);
        pulse_vld(); pulse_vld();
        drain("t3a");
        chk("t3a_sat_pos", got[0], 8'd127);
        chk("t3a_sat_neg", got[1], 8'h80);
        chk("t3a_neg",     got[2], 8'hFA);
        cfg_relu = 1'b1;
        pulse_vld(); pulse_vld();
        drain("t3b");
        chk("t3b_sat_pos", got[0], 8'd127);
        chk("t3b_relu1",   got[1], 8'd0);
        chk("t3b_relu2",   got[2], 8'd0);

        // 4: alternating back-pressure from DRAIN entry
        cfg_ngrp = 8'd0; cfg_relu = 1'b0; psum_i = '0;
        for (int f = 0; f < NF; f++) set_psum(f, f + 1);
        out_rdy_i = 1'b0;
        pulse_vld();
        step();
        begin
            int acc_n = 0;
            for (int c = 0; c < 200 && acc_n < NF; c++) begin
                out_rdy_i = (c % 2 == 0);
                chk("t4_vld",  out_vld_o,  1'b1);
                chk("t4_idx",  out_idx_o,  acc_n);
                chk("t4_data", out_data_o, acc_n + 1);
                chk("t4_rdy_low", psum_rdy_o, 1'b0);
                if (out_rdy_i) acc_n++;
                step();
            end
            chk("t4_accepted", acc_n, NF);
        end
        chk("t4_vld_end", out_vld_o, 1'b0);
        chk("t4_rdy_back", psum_rdy_o, 1'b1);

        // 5: psum_vld_i during DRAIN is dropped and sets sticky err_o
        cfg_ngrp = 8'd1; psum_i = '0;
        for (int f = 0; f < NF; f++) set_psum(f, 2 * f);
        out_rdy_i = 1'b0;
        pulse_vld();
        step();
        for (int f = 0; f < NF; f++) set_psum(f, 99);
        pulse_vld();
        chk("t5_err",  err_o,      1'b1);
        chk("t5_vld",  out_vld_o,  1'b1);
        chk("t5_idx",  out_idx_o,  6'd0);
        chk("t5_data", out_data_o, 8'd0);
        drain("t5a");
        chk("t5a_lane5",  got[5],  8'd10);
        chk("t5a_lane39", got[39], 8'd78);
        for (int f = 0; f < NF; f++) set_psum(f, 3);
        pulse_vld();
        drain("t5b");
        chk("t5b_lane39", got[39], 8'd3);
        chk("t5b_err_sticky", err_o, 1'b1);

        // 6: reset mid-drain aborts the pixel
        for (int f = 0; f < NF; f++) set_psum(f, 7);
        out_rdy_i = 1'b1;
        pulse_vld();
        step();
        for (int k = 0; k < 18; k++) step();
        chk("t6_idx18", out_idx_o, 6'd18);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_vld", out_vld_o, 1'b0);
        chk("t6_rdy", psum_rdy_o, 1'b1);
        chk("t6_err", err_o, 1'b0);
        for (int f = 0; f < NF; f++) set_psum(f, 5);
        pulse_vld();
        step();
        chk("t6_next_vld",  out_vld_o,  1'b1);
        chk("t6_next_idx",  out_idx_o,  6'd0);
        chk("t6_next_data", out_data_o, 8'd5);
        drain("t6");
        chk("t6_lane39", got[39], 8'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
